// File: rtl/branch_resolve_unit.sv
// Two-stage branch resolution unit: resolves RISC-V conditional branches, checks the
// front-end prediction, and keeps a saturating count of delivered mispredicts.
module branch_resolve_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_pred_taken,
    input  logic [XLEN-1:0]  in_pred_target,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_next_pc,
    output logic             out_mispredict,
    output logic             out_illegal,
    output logic [CNT_W-1:0] mispredict_count
);

    typedef enum logic [2:0] {
        F_BEQ  = 3'b000,
        F_BNE  = 3'b001,
        F_BLT  = 3'b100,
        F_BGE  = 3'b101,
        F_BLTU = 3'b110,
        F_BGEU = 3'b111
    } funct3_e;

    logic             advance;

    logic             s1_valid_q, s1_valid_d;
    logic [2:0]       s1_funct3_q, s1_funct3_d;
    logic [XLEN-1:0]  s1_rs1_q, s1_rs1_d;
    logic [XLEN-1:0]  s1_rs2_q, s1_rs2_d;
    logic [XLEN-1:0]  s1_pc_q, s1_pc_d;
    logic [XLEN-1:0]  s1_imm_q, s1_imm_d;
    logic             s1_pred_taken_q, s1_pred_taken_d;
    logic [XLEN-1:0]  s1_pred_target_q, s1_pred_target_d;

    logic             out_valid_q, out_valid_d;
    logic             out_taken_q, out_taken_d;
    logic [XLEN-1:0]  out_next_pc_q, out_next_pc_d;
    logic             out_mispredict_q, out_mispredict_d;
    logic             out_illegal_q, out_illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             eq, lt_s, lt_u;
    logic             res_taken, res_illegal, res_mispredict;
    logic [XLEN-1:0]  res_next_pc;

    assign advance = !out_valid_q || out_ready;
    assign in_ready = advance;

    always_comb begin
        eq          = (s1_rs1_q == s1_rs2_q);
        lt_s        = ($signed(s1_rs1_q) < $signed(s1_rs2_q));
        lt_u        = (s1_rs1_q < s1_rs2_q);
        res_taken   = 1'b0;
        res_illegal = 1'b0;
        case (s1_funct3_q)
            F_BEQ:   res_taken = eq;
            F_BNE:   res_taken = !eq;
            F_BLT:   res_taken = lt_s;
            F_BGE:   res_taken = !lt_s;
            F_BLTU:  res_taken = lt_u;
            F_BGEU:  res_taken = !lt_u;
            default: res_illegal = 1'b1;
        endcase
        res_next_pc = res_taken ? (s1_pc_q + s1_imm_q) : (s1_pc_q + XLEN'(4));
        res_mispredict = !res_illegal &&
                         ((res_taken != s1_pred_taken_q) ||
                          (res_taken && (s1_pred_target_q != res_next_pc)));
    end

    always_comb begin
        s1_valid_d       = s1_valid_q;
        s1_funct3_d      = s1_funct3_q;
        s1_rs1_d         = s1_rs1_q;
        s1_rs2_d         = s1_rs2_q;
        s1_pc_d          = s1_pc_q;
        s1_imm_d         = s1_imm_q;
        s1_pred_taken_d  = s1_pred_taken_q;
        s1_pred_target_d = s1_pred_target_q;
        out_valid_d      = out_valid_q;
        out_taken_d      = out_taken_q;
        out_next_pc_d    = out_next_pc_q;
        out_mispredict_d = out_mispredict_q;
        out_illegal_d    = out_illegal_q;
        cnt_d            = cnt_q;

        if (advance) begin
            s1_valid_d       = in_valid;
            s1_funct3_d      = in_funct3;
            s1_rs1_d         = in_rs1;
            s1_rs2_d         = in_rs2;
            s1_pc_d          = in_pc;
            s1_imm_d         = in_imm;
            s1_pred_taken_d  = in_pred_taken;
            s1_pred_target_d = in_pred_target;
            out_valid_d      = s1_valid_q;
            out_taken_d      = res_taken;
            out_next_pc_d    = res_next_pc;
            out_mispredict_d = res_mispredict;
            out_illegal_d    = res_illegal;
        end

        // Flush only kills valids; a result leaving this cycle is still counted below.
        if (flush) begin
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end

        if (out_valid_q && out_ready && out_mispredict_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q       <= 1'b0;
            s1_funct3_q      <= '0;
            s1_rs1_q         <= '0;
            s1_rs2_q         <= '0;
            s1_pc_q          <= '0;
            s1_imm_q         <= '0;
            s1_pred_taken_q  <= 1'b0;
            s1_pred_target_q <= '0;
            out_valid_q      <= 1'b0;
            out_taken_q      <= 1'b0;
            out_next_pc_q    <= '0;
            out_mispredict_q <= 1'b0;
            out_illegal_q    <= 1'b0;
            cnt_q            <= '0;
        end else begin
            s1_valid_q       <= s1_valid_d;
            s1_funct3_q      <= s1_funct3_d;
            s1_rs1_q         <= s1_rs1_d;
            s1_rs2_q         <= s1_rs2_d;
            s1_pc_q          <= s1_pc_d;
            s1_imm_q         <= s1_imm_d;
            s1_pred_taken_q  <= s1_pred_taken_d;
            s1_pred_target_q <= s1_pred_target_d;
            out_valid_q      <= out_valid_d;
            out_taken_q      <= out_taken_d;
            out_next_pc_q    <= out_next_pc_d;
            out_mispredict_q <= out_mispredict_d;
            out_illegal_q    <= out_illegal_d;
            cnt_q            <= cnt_d;
        end
    end

    assign out_valid        = out_valid_q;
    assign out_taken        = out_taken_q;
    assign out_next_pc      = out_next_pc_q;
    assign out_mispredict   = out_mispredict_q;
    assign out_illegal      = out_illegal_q;
    assign mispredict_count = cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus random traffic checked against
// an in-order queue model of expected results and a saturating mispredict tally.
module tb_branch_resolve_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_funct3;
    logic [XLEN-1:0]  in_rs1, in_rs2, in_pc, in_imm, in_pred_target;
    logic             in_pred_taken;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic             out_taken;
    logic [XLEN-1:0]  out_next_pc;
    logic             out_mispredict;
    logic             out_illegal;
    logic [CNT_W-1:0] mispredict_count;

    branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc), .in_imm(in_imm),
        .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_taken(out_taken), .out_next_pc(out_next_pc),
        .out_mispredict(out_mispredict), .out_illegal(out_illegal),
        .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        taken;
        logic [31:0] next_pc;
        logic        mis;
        logic        ill;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    int          ndeliv = 0;
    int unsigned mcnt = 0;
    int unsigned cnt_max = (1 << CNT_W) - 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] pc, input logic [31:0] imm,
                                   input logic pt, input logic [31:0] ptg);
        exp_t r;
        longint signed   sa = longint'($signed(a));
        longint signed   sb = longint'($signed(b));
        longint unsigned ua = longint'(a);
        longint unsigned ub = longint'(b);
        longint unsigned sum;
        r.ill = (f == 3'd2) || (f == 3'd3);
        case (f)
            3'd0: r.taken = (ua == ub);
            3'd1: r.taken = (ua != ub);
            3'd4: r.taken = (sa < sb);
            3'd5: r.taken = (sa >= sb);
            3'd6: r.taken = (ua < ub);
            3'd7: r.taken = (ua >= ub);
            default: r.taken = 1'b0;
        endcase
        sum = r.taken ? (longint'(pc) + longint'(imm)) : (longint'(pc) + 64'd4);
        r.next_pc = 32'(sum % 64'h1_0000_0000);
        r.mis = !r.ill && ((r.taken != pt) || (r.taken && (ptg != r.next_pc)));
        return r;
    endfunction

    // One clock: observe at the falling edge, update the model for the coming rising edge.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        check("in_ready_rule", in_ready, !out_valid || out_ready);
        check("count", mispredict_count, mcnt);
        if (rst) begin
            q.delete();
            mcnt = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("spurious_out", out_valid, 1'b0);
                end else begin
                    e = q.pop_front();
                    ndeliv++;
                    check("taken", out_taken, e.taken);
                    check("next_pc", out_next_pc, e.next_pc);
                    check("mispredict", out_mispredict, e.mis);
                    check("illegal", out_illegal, e.ill);
                    if (e.mis && mcnt < cnt_max) mcnt++;
                end
            end
            if (in_valid && in_ready && !flush)
                q.push_back(model(in_funct3, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken, in_pred_target));
            if (flush) q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] pc, input logic [31:0] imm,
                           input logic pt, input logic [31:0] ptg);
        in_valid = 1'b1; in_funct3 = f; in_rs1 = a; in_rs2 = b;
        in_pc = pc; in_imm = imm; in_pred_taken = pt; in_pred_target = ptg;
    endtask

    logic        snap_taken, snap_mis, snap_ill;
    logic [31:0] snap_pc;
    int          nd0;

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
        set_req(3'd0, '0, '0, '0, '0, 1'b0, '0);
        in_valid = 1'b0;
        cyc(); cyc();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_taken", out_taken, 1'b0);
        check("rst_next_pc", out_next_pc, 32'h0);
        check("rst_mis", out_mispredict, 1'b0);
        check("rst_ill", out_illegal, 1'b0);
        check("rst_count", mispredict_count, 0);
        rst = 1'b0;
        cyc();

        // BLT signed, two-cycle latency
        set_req(3'd4, 32'hFFFF0000, 32'hFFFFFFFF, 32'h100, 32'h20, 1'b1, 32'h120);
        cyc();
        in_valid = 1'b0;
        check("t1_lat1_valid", out_valid, 1'b0);
        cyc();
        check("t1_valid", out_valid, 1'b1);
        check("t1_taken", out_taken, 1'b1);
        check("t1_next_pc", out_next_pc, 32'h120);
        check("t1_mis", out_mispredict, 1'b0);
        cyc();

        // BLTU, equal operands, predicted taken
        set_req(3'd6, 32'hFFFF0000, 32'hFFFF0000, 32'h100, 32'h20, 1'b1, 32'h120);
        cyc();
        in_valid = 1'b0;
        cyc();
        check("t2_taken", out_taken, 1'b0);
        check("t2_next_pc", out_next_pc, 32'h104);
        check("t2_mis", out_mispredict, 1'b1);
        cyc();
        check("t2_count", mispredict_count, 1);

        // BEQ with PC wrap
        set_req(3'd0, 32'd20, 32'd20, 32'hFFFFFFFC, 32'h8, 1'b1, 32'h4);
        cyc();
        in_valid = 1'b0;
        cyc();
        check("t3_taken", out_taken, 1'b1);
        check("t3_next_pc", out_next_pc, 32'h4);
        cyc();

        // Backpressure: three back-to-back with consumer stalled
        nd0 = ndeliv;
        out_ready = 1'b0;
        set_req(3'd1, 32'd1, 32'd2, 32'h200, 32'h40, 1'b1, 32'h240);
        cyc();
        set_req(3'd5, 32'd5, 32'd3, 32'h300, 32'h10, 1'b0, 32'h0);
        cyc();
        set_req(3'd7, 32'd1, 32'd9, 32'h400, 32'h80, 1'b1, 32'h480);
        check("t4_full_in_ready", in_ready, 1'b0);
        snap_taken = out_taken; snap_pc = out_next_pc; snap_mis = out_mispredict; snap_ill = out_illegal;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("t4_stall_in_ready", in_ready, 1'b0);
            check("t4_stall_valid", out_valid, 1'b1);
            check("t4_hold_taken", out_taken, snap_taken);
            check("t4_hold_pc", out_next_pc, snap_pc);
            check("t4_hold_mis", out_mispredict, snap_mis);
            check("t4_hold_ill", out_illegal, snap_ill);
        end
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        repeat (4) cyc();
        check("t4_delivered", ndeliv - nd0, 3);
        check("t4_queue_empty", q.size(), 0);

        // Flush with two in flight and a new request in the same cycle
        nd0 = ndeliv;
        out_ready = 1'b0;
        set_req(3'd0, 32'd1, 32'd2, 32'h500, 32'h10, 1'b1, 32'h510);
        cyc();
        set_req(3'd1, 32'd3, 32'd3, 32'h600, 32'h10, 1'b1, 32'h610);
        cyc();
        set_req(3'd4, 32'd1, 32'd2, 32'h700, 32'h10, 1'b0, 32'h0);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        in_valid = 1'b0;
        check("t5_flushed_valid", out_valid, 1'b0);
        out_ready = 1'b1;
        repeat (4) cyc();
        check("t5_no_results", ndeliv - nd0, 0);

        // Illegal funct3
        set_req(3'd2, 32'd7, 32'd7, 32'h800, 32'h10, 1'b1, 32'h810);
        cyc();
        in_valid = 1'b0;
        cyc();
        check("t6_ill", out_illegal, 1'b1);
        check("t6_ill_taken", out_taken, 1'b0);
        check("t6_ill_mis", out_mispredict, 1'b0);
        cyc();

        // Saturation: five mispredicts from zero on a 2-bit counter
        rst = 1'b1; cyc(); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_req(3'd0, 32'd1, 32'd2, 32'h900 + 32'(i * 4), 32'h10, 1'b1, 32'h0);
            cyc();
        end
        in_valid = 1'b0;
        repeat (4) cyc();
        check("t6_saturate", mispredict_count, 3);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, b, pc, imm, tgt;
            logic [2:0]  f;
            logic        pt;
            f   = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            pc  = $urandom & 32'hFFFFFFFC;
            imm = 32'($signed(13'($urandom) & 13'h1FFE));
            pt  = 1'($urandom);
            tgt = ($urandom_range(0, 3) != 0) ? (pc + imm) : $urandom;
            set_req(f, a, b, pc, imm, pt, tgt);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            cyc();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) cyc();
        check("rand_drain", q.size(), 0);

        // Reset in the middle of traffic
        out_ready = 1'b0;
        set_req(3'd1, 32'd1, 32'd2, 32'hA00, 32'h10, 1'b0, 32'h0);
        cyc(); cyc();
        nd0 = ndeliv;
        rst = 1'b1;
        cyc();
        check("rst_mid_valid", out_valid, 1'b0);
        check("rst_mid_taken", out_taken, 1'b0);
        check("rst_mid_pc", out_next_pc, 32'h0);
        check("rst_mid_count", mispredict_count, 0);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) cyc();
        check("rst_mid_no_results", ndeliv - nd0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
